// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage RISC-V pipeline: load-use stalls,
// taken-branch flushes, data-memory wait holds, event counters and a timeout trap.
module pipeline_ctrl #(
  parameter int unsigned  MEM_TIMEOUT    = 255,
  parameter logic [31:0]  STALL_CNT_INIT = 32'd0,
  parameter logic [31:0]  FLUSH_CNT_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [6:0]  ex_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        ena_ifid,
  output logic        flush_ifid,
  output logic        ena_idex,
  output logic        hold_idex,
  output logic        ena_exmem,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        lu, mw;

  always_comb begin
    lu = (ex_op == OP_LOAD) && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    mw = mem_req && !mem_ack;
  end

  // Stage-register controls; the ERROR check comes first so counters freeze there.
  always_comb begin
    pc_en       = 1'b0;
    ena_ifid    = 1'b0;
    flush_ifid  = 1'b0;
    ena_idex    = 1'b0;
    hold_idex   = 1'b0;
    ena_exmem   = 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      // all controls low: ID/EX is cleared to a bubble while in reset
    end else if (state_q == ST_ERROR) begin
      hold_idex = 1'b1;
    end else if (mw) begin
      ena_idex    = 1'b1;
      hold_idex   = 1'b1;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (ex_branch_taken) begin
      pc_en       = 1'b1;
      ena_ifid    = 1'b1;
      flush_ifid  = 1'b1;
      ena_exmem   = 1'b1;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (lu) begin
      ena_exmem   = 1'b1;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      pc_en     = 1'b1;
      ena_ifid  = 1'b1;
      ena_idex  = 1'b1;
      ena_exmem = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_timeout_d = mem_timeout_q;
    wait_cnt_d    = mw ? wait_cnt_q + 16'd1 : 16'd0;
    case (state_q)
      ST_RUN: begin
        if (mw) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (!mw) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d       = ST_ERROR;
          mem_timeout_d = 1'b1;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= STALL_CNT_INIT;
      flush_cnt_q   <= FLUSH_CNT_INIT;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl, plus a counter-saturation
// sequence on a second instance whose counters reset near the top.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [6:0]  ex_op = '0;
  logic        ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;

  logic        pc_en, ena_ifid, flush_ifid, ena_idex, hold_idex, ena_exmem, mem_timeout;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_ena_ifid, s_flush_ifid, s_ena_idex, s_hold_idex, s_ena_exmem, s_mem_timeout;
  logic [1:0]  s_state;
  logic [31:0] s_stall_cnt, s_flush_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ena_ifid(ena_ifid), .flush_ifid(flush_ifid), .ena_idex(ena_idex),
    .hold_idex(hold_idex), .ena_exmem(ena_exmem), .state(state),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(255), .STALL_CNT_INIT(32'hFFFF_FFFD),
                  .FLUSH_CNT_INIT(32'hFFFF_FFFF)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(s_pc_en), .ena_ifid(s_ena_ifid), .flush_ifid(s_flush_ifid), .ena_idex(s_ena_idex),
    .hold_idex(s_hold_idex), .ena_exmem(s_ena_exmem), .state(s_state),
    .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Control word order: {pc_en, ena_ifid, flush_ifid, ena_idex, hold_idex, ena_exmem}
  localparam logic [5:0] C_RST  = 6'b000000;
  localparam logic [5:0] C_NORM = 6'b110101;
  localparam logic [5:0] C_MW   = 6'b000110;
  localparam logic [5:0] C_BR   = 6'b111001;
  localparam logic [5:0] C_LU   = 6'b000001;
  localparam logic [5:0] C_ERR  = 6'b000010;
  localparam logic [6:0] LD     = 7'b0000011;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic        br, req, ack;
    logic [5:0]  ctrl;
    logic [1:0]  st;
    logic [31:0] stall, flush;
    logic        tmo;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [6:0] op, input logic [4:0] rd,
                     input logic br, input logic req, input logic ack, input logic [5:0] ctrl,
                     input logic [1:0] st, input logic [31:0] stall, input logic [31:0] flush,
                     input logic tmo);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.op = op; v.rd = rd;
    v.br = br; v.req = req; v.ack = ack; v.ctrl = ctrl; v.st = st;
    v.stall = stall; v.flush = flush; v.tmo = tmo;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [6:0] op,
                       input logic [4:0] rd, input logic br, input logic req, input logic ack);
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_op = op; ex_rd = rd; ex_branch_taken = br; mem_req = req; mem_ack = ack;
  endtask

  initial begin
    //  rst rs1 rs2 u1 u2 op  rd br req ack  ctrl    st stall flush tmo
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  C_RST,  0, 0,  0, 0);   // reset
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  C_NORM, 0, 0,  0, 0);   // first cycle after reset
    add(0, 1, 5, 1, 1, LD, 5, 0, 0, 0,  C_LU,   0, 1,  0, 0);   // load-use on rs2
    add(0, 1, 5, 1, 1, 0,  0, 0, 0, 0,  C_NORM, 0, 1,  0, 0);   // bubble in EX
    add(0, 0, 0, 1, 1, LD, 0, 0, 0, 0,  C_NORM, 0, 1,  0, 0);   // rd = x0
    add(0, 1, 5, 1, 0, LD, 5, 0, 0, 0,  C_NORM, 0, 1,  0, 0);   // rs2 not used
    add(0, 7, 2, 1, 0, LD, 7, 0, 0, 0,  C_LU,   0, 2,  0, 0);   // load-use on rs1
    add(0, 7, 2, 1, 0, LD, 7, 1, 0, 0,  C_BR,   0, 2,  1, 0);   // branch beats LU
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 3,  1, 0);   // memory wait x3
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 4,  1, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 5,  1, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1,  C_NORM, 0, 5,  1, 0);   // ack
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 0,  C_MW,   1, 6,  1, 0);   // wait beats branch
    add(0, 0, 0, 0, 0, 0,  0, 1, 1, 1,  C_BR,   0, 6,  2, 0);   // flush lands on ack
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 7,  2, 0);   // timeout run
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 8,  2, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 9,  2, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   2, 10, 2, 1);   // 4th wait -> ERROR
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1,  C_ERR,  2, 10, 2, 1);   // late ack ignored
    add(0, 1, 5, 1, 1, LD, 5, 1, 1, 0,  C_ERR,  2, 10, 2, 1);   // frozen in ERROR
    add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0,  C_RST,  0, 0,  0, 0);   // reset out of ERROR
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  C_NORM, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 1,  0, 0);   // three waits
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 2,  0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 3,  0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 1,  C_NORM, 0, 3,  0, 0);   // ack on timeout cycle wins
    add(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_MW,   1, 4,  0, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 1, 0,  C_RST,  0, 0,  0, 0);   // reset mid-wait

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].op, vt[i].rd,
            vt[i].br, vt[i].req, vt[i].ack);
      #1;
      chk($sformatf("v%0d ctrl", i),
          {26'd0, pc_en, ena_ifid, flush_ifid, ena_idex, hold_idex, ena_exmem},
          {26'd0, vt[i].ctrl});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d state", i), {30'd0, state}, {30'd0, vt[i].st});
      chk($sformatf("v%0d stall_cnt", i), stall_cnt, vt[i].stall);
      chk($sformatf("v%0d flush_cnt", i), flush_cnt, vt[i].flush);
      chk($sformatf("v%0d mem_timeout", i), {31'd0, mem_timeout}, {31'd0, vt[i].tmo});
    end

    // Saturation: stall counter starts at FFFFFFFD after reset, flush at FFFFFFFF.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("sat reset stall", s_stall_cnt, 32'hFFFF_FFFD);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(posedge clk); #1;
      chk($sformatf("sat wait%0d stall", k), s_stall_cnt,
          (k == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    #1;
    chk("sat branch flush_ifid", {31'd0, s_flush_ifid}, 32'd1);
    @(posedge clk); #1;
    chk("sat flush_cnt", s_flush_cnt, 32'hFFFF_FFFF);
    chk("sat state", {30'd0, s_state}, 32'd0);
    @(negedge clk);
    drive(0, 1, 5, 0, 1, LD, 5, 0, 0, 0);
    @(posedge clk); #1;
    chk("sat lu stall", s_stall_cnt, 32'hFFFF_FFFF);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the 5-stage RISC-V pipeline. It drives the enable, flush and hold controls of the IF/ID, ID/EX and EX/MEM stage registers and the PC write enable. Inputs are ID-stage operand usage, the ID/EX outputs, the EX branch result and the data-memory handshake. It resolves load-use hazards, taken-branch flushes and multi-cycle memory waits, counts stall and flush events, and traps to an error state on a memory timeout.

## Interface
- MEM_TIMEOUT, 255: consecutive unacknowledged memory-request cycles before entering ERROR; range 2..65535.
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the instruction in ID reads rs1 / rs2
- ex_op  in  7  opcode held in ID/EX (op_out)
- ex_rd  in  5  destination held in ID/EX (rd_out)
- ex_branch_taken  in  1  branch/jal/jalr resolved taken in EX
- mem_req  in  1  load/store in MEM stage requests data memory
- mem_ack  in  1  data memory completes the request this cycle
- pc_en  out  1  PC register loads next PC
- ena_ifid  out  1  IF/ID register loads
- flush_ifid  out  1  IF/ID register clears to NOP
- ena_idex  out  1  ID/EX loads when 1; clears to bubble (all zero) when 0
- hold_idex  out  1  ID/EX retains contents; overrides ena_idex
- ena_exmem  out  1  EX/MEM register loads
- state  out  2  0 RUN, 1 MEM_WAIT, 2 ERROR
- mem_timeout  out  1  sticky timeout flag
- stall_cnt  out  32  stall cycles, saturating
- flush_cnt  out  32  branch flushes, saturating

## Operation
- Load-use condition LU: ex_op == 7'b0000011, ex_rd != 0, and ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
- Memory-wait condition MW: mem_req && !mem_ack.
- Control outputs are combinational from state and inputs. Priority is ERROR > MW > ex_branch_taken > LU > normal.
- Normal: pc_en=1, ena_ifid=1, ena_idex=1, ena_exmem=1, flush_ifid=0, hold_idex=0.
- MW: pc_en=0, ena_ifid=0, hold_idex=1, ena_idex=1, ena_exmem=0, flush_ifid=0. stall_cnt increments.
- Branch: pc_en=1, ena_ifid=1, flush_ifid=1, ena_idex=0 (bubble), ena_exmem=1. flush_cnt increments once per cycle asserted.
- LU: pc_en=0, ena_ifid=0, ena_idex=0 (bubble), ena_exmem=1, flush_ifid=0. stall_cnt increments.
- FSM transitions:
  - RUN goes to MEM_WAIT on MW.
  - MEM_WAIT goes to RUN on a cycle with !MW.
  - MEM_WAIT goes to ERROR when wait_cnt == MEM_TIMEOUT-1 and MW still holds.
  - ERROR is left only by rst.
- wait_cnt (16 bit, internal): increments on each MW cycle; clears on any !MW cycle.
- ERROR: all enables 0, flush_ifid=0, hold_idex=1, mem_timeout=1, counters frozen.
- Counters saturate at 32'hFFFFFFFF and never wrap.

## Timing
- While rst=1: pc_en, ena_ifid, ena_idex, ena_exmem, flush_ifid and hold_idex are all 0, which clears ID/EX to a bubble each cycle. At the edge, state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- First cycle after rst falls: normal outputs unless a condition applies.
- LU stall lasts exactly 1 cycle. The bubble in ID/EX has op=0, so LU cannot re-fire the next cycle.
- A taken branch costs 2 bubbles (IF/ID flushed and ID/EX bubbled in the same cycle). Branch never coincides with LU-on-the-flushed-instruction.
- MW with ex_branch_taken: EX is held, so ex_branch_taken stays high. The flush applies on the mem_ack cycle and flush_cnt increments once.
- mem_ack in the same cycle as the would-be timeout: ack wins, state goes to RUN.
- Reset mid-MEM_WAIT or in ERROR: returns to RUN next cycle with counters cleared.

## Test plan
- lw x5 in EX (ex_op=0000011, ex_rd=5), ID add with id_rs2=5, id_use_rs2=1 -> one cycle of pc_en=0, ena_ifid=0, ena_idex=0; stall_cnt=1; next cycle normal.
- Same as above with ex_rd=0, or with id_use_rs2=0 -> no stall; stall_cnt stays 0.
- ex_branch_taken=1 for one cycle together with LU true -> flush_ifid=1, ena_idex=0, pc_en=1; flush_cnt=1; stall_cnt=0.
- mem_req=1, mem_ack low for 3 cycles then high -> state=1 for 3 cycles with hold_idex=1 and pc_en=0; stall_cnt=3; state=0 after the ack edge.
- MEM_TIMEOUT=4, mem_req=1, mem_ack=0 held -> state=2 and mem_timeout=1 from cycle 4. Asserting mem_ack afterwards has no effect. rst -> state=0, mem_timeout=0, counters 0.
- Preload stall_cnt near saturation by forcing 2^32+ stall cycles (or a test-only preset), continue MW -> stall_cnt holds at FFFFFFFF.
